// File: rtl/btn_event_gen.sv
// Debounced multi-button event generator.
// Each channel is synchronised, debounced on a shared millisecond tick, and
// tracked by a small IDLE/HELD/LONG machine. The machine emits one-cycle
// press, long-press, auto-repeat and release pulses.
module btn_event_gen #(
  parameter int N_BTN       = 4,
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200,
  parameter bit ACTIVE_LOW  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] button_in,
  output logic [N_BTN-1:0] btn_stable,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse,
  output logic [N_BTN-1:0] repeat_pulse
);

  localparam int TICK_DIV = CLK_FREQ_HZ / 1000;
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_END = PRE_W'(TICK_DIV - 1);

  localparam int DB_W = $clog2(DEBOUNCE_MS + 1);
  localparam logic [DB_W-1:0] DB_END = DB_W'(DEBOUNCE_MS - 1);

  localparam int HOLD_MAX = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] LONG_END   = HOLD_W'(LONG_MS - 1);
  localparam logic [HOLD_W-1:0] REPEAT_END = HOLD_W'((REPEAT_MS > 0) ? (REPEAT_MS - 1) : 0);
  localparam bit REPEAT_EN = (REPEAT_MS > 0);

  // A released button reads as the inactive pin level.
  localparam logic [N_BTN-1:0] SYNC_IDLE = {N_BTN{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } state_t;

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;
  logic [N_BTN-1:0] w_raw;
  logic [PRE_W-1:0] r_pre;
  logic             w_msTick;
  logic             r_msTickD;

  // Two-flop synchroniser for the asynchronous pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= SYNC_IDLE;
      r_sync2 <= SYNC_IDLE;
    end else begin
      r_sync1 <= button_in;
      r_sync2 <= r_sync1;
    end
  end

  // Normalise polarity so that 1 always means pressed.
  assign w_raw = r_sync2 ^ SYNC_IDLE;

  // Shared prescaler producing a one-cycle tick each millisecond.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
    end else if (w_msTick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  assign w_msTick = (r_pre == PRE_END);

  // The hold machines react to a debounced edge one cycle late, so they also
  // see the tick one cycle late; a fall that lands on a tick then coincides
  // with the delayed tick and can take priority over it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_msTickD <= 1'b0;
    end else begin
      r_msTickD <= w_msTick;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    logic [DB_W-1:0]   r_dbCnt;
    logic              r_stable;
    logic              r_stableD;
    state_t            r_state;
    state_t            w_stateNext;
    logic [HOLD_W-1:0] r_holdCnt;
    logic [HOLD_W-1:0] w_holdNext;
    logic              w_rise;
    logic              w_fall;
    logic              r_press;
    logic              r_release;
    logic              r_long;
    logic              r_repeat;
    logic              w_pressNext;
    logic              w_releaseNext;
    logic              w_longNext;
    logic              w_repeatNext;

    // Debounce: the level must disagree for DEBOUNCE_MS consecutive ticks.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_dbCnt  <= '0;
        r_stable <= 1'b0;
      end else if (w_raw[i] == r_stable) begin
        r_dbCnt <= '0;
      end else if (w_msTick) begin
        if (r_dbCnt == DB_END) begin
          r_stable <= w_raw[i];
          r_dbCnt  <= '0;
        end else begin
          r_dbCnt <= r_dbCnt + DB_W'(1);
        end
      end
    end

    assign w_rise = r_stable & ~r_stableD;
    assign w_fall = ~r_stable & r_stableD;

    // State, hold counter, edge-detect copy and registered pulse outputs.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_stableD <= 1'b0;
        r_state   <= IDLE;
        r_holdCnt <= '0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
        r_repeat  <= 1'b0;
      end else begin
        r_stableD <= r_stable;
        r_state   <= w_stateNext;
        r_holdCnt <= w_holdNext;
        r_press   <= w_pressNext;
        r_release <= w_releaseNext;
        r_long    <= w_longNext;
        r_repeat  <= w_repeatNext;
      end
    end

    // Next state and hold counter; a debounced fall always wins.
    always_comb begin
      w_stateNext = r_state;
      w_holdNext  = r_holdCnt;
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            w_stateNext = HELD;
            w_holdNext  = '0;
          end
        end
        HELD: begin
          if (w_fall) begin
            w_stateNext = IDLE;
            w_holdNext  = '0;
          end else if (r_msTickD) begin
            if (r_holdCnt == LONG_END) begin
              w_stateNext = LONG;
              w_holdNext  = '0;
            end else begin
              w_holdNext = r_holdCnt + HOLD_W'(1);
            end
          end
        end
        LONG: begin
          if (w_fall) begin
            w_stateNext = IDLE;
            w_holdNext  = '0;
          end else if (REPEAT_EN && r_msTickD) begin
            if (r_holdCnt == REPEAT_END) begin
              w_holdNext = '0;
            end else begin
              w_holdNext = r_holdCnt + HOLD_W'(1);
            end
          end
        end
        default: begin
          w_stateNext = IDLE;
          w_holdNext  = '0;
        end
      endcase
    end

    // Pulse decode; the conditions are mutually exclusive by construction.
    always_comb begin
      w_pressNext   = 1'b0;
      w_releaseNext = 1'b0;
      w_longNext    = 1'b0;
      w_repeatNext  = 1'b0;
      case (r_state)
        IDLE: begin
          w_pressNext = w_rise;
        end
        HELD: begin
          w_releaseNext = w_fall;
          w_longNext    = ~w_fall & r_msTickD & (r_holdCnt == LONG_END);
        end
        LONG: begin
          w_releaseNext = w_fall;
          w_repeatNext  = REPEAT_EN & ~w_fall & r_msTickD & (r_holdCnt == REPEAT_END);
        end
        default: begin
          w_pressNext = 1'b0;
        end
      endcase
    end

    assign btn_stable[i]    = r_stable;
    assign press_pulse[i]   = r_press;
    assign release_pulse[i] = r_release;
    assign long_pulse[i]    = r_long;
    assign repeat_pulse[i]  = r_repeat;
  end

endmodule

// File: tb/tb_btn_event_gen.sv
// Self-checking bench for btn_event_gen: a table of timed pin segments with
// expected per-channel pulse counts, followed by cycle-exact sequences for
// press latency, long/repeat timing, fall-vs-long priority and mid-hold reset.
// Time base: one ms tick every 10 clocks, ticks on edges 10, 20, ... after reset.
module tb_btn_event_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] button_in = 4'hF;
  logic [3:0] btn_stable;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;
  logic [3:0] long_pulse;
  logic [3:0] repeat_pulse;

  int checks   = 0;
  int failures = 0;
  int k        = 0;
  int overlaps = 0;
  int cntPress[4];
  int cntRelease[4];
  int cntLong[4];
  int cntRepeat[4];

  typedef struct {
    logic [3:0]  pins;
    int          cycles;
    logic [3:0]  expStable;
    logic [15:0] expPress;
    logic [15:0] expRelease;
    logic [15:0] expLong;
    logic [15:0] expRepeat;
  } vec_t;

  vec_t vecs[17];

  btn_event_gen #(
    .N_BTN(4),
    .CLK_FREQ_HZ(10_000),
    .DEBOUNCE_MS(3),
    .LONG_MS(20),
    .REPEAT_MS(5),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .button_in(button_in),
    .btn_stable(btn_stable),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse),
    .repeat_pulse(repeat_pulse)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at k=%0d: got %0h expected %0h", name, k, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] pins);
    button_in = pins;
  endtask

  task automatic clearCounts();
    for (int i = 0; i < 4; i++) begin
      cntPress[i]   = 0;
      cntRelease[i] = 0;
      cntLong[i]    = 0;
      cntRepeat[i]  = 0;
    end
  endtask

  // Advance one clock, sampling outputs on the falling edge.
  task automatic cycle();
    int n;
    @(negedge clk);
    k++;
    for (int i = 0; i < 4; i++) begin
      n = int'(press_pulse[i]) + int'(release_pulse[i]) + int'(long_pulse[i]) + int'(repeat_pulse[i]);
      if (n > 1) overlaps++;
      cntPress[i]   += int'(press_pulse[i]);
      cntRelease[i] += int'(release_pulse[i]);
      cntLong[i]    += int'(long_pulse[i]);
      cntRepeat[i]  += int'(repeat_pulse[i]);
    end
  endtask

  task automatic runTo(input int target);
    while (k < target) cycle();
  endtask

  function automatic logic [15:0] packCounts(input int c[4]);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'(c[i]);
    return r;
  endfunction

  initial begin
    // Segments start where the previous one ended; k counts edges since reset.
    vecs[0]  = '{4'hF, 10,  4'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[1]  = '{4'hE, 90,  4'h1, 16'h0001, 16'h0000, 16'h0000, 16'h0000};
    vecs[2]  = '{4'hF, 50,  4'h0, 16'h0000, 16'h0001, 16'h0000, 16'h0000};
    for (int g = 0; g < 5; g++) begin
      vecs[3 + 2*g] = '{4'hD, 15, 4'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      vecs[4 + 2*g] = '{4'hF, 15, 4'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    end
    vecs[13] = '{4'h6, 60,  4'h9, 16'h1001, 16'h0000, 16'h0000, 16'h0000};
    vecs[14] = '{4'hF, 40,  4'h0, 16'h0000, 16'h1001, 16'h0000, 16'h0000};
    vecs[15] = '{4'hB, 400, 4'h4, 16'h0100, 16'h0000, 16'h0100, 16'h0300};
    vecs[16] = '{4'hF, 60,  4'h0, 16'h0000, 16'h0100, 16'h0000, 16'h0000};

    repeat (3) @(negedge clk);
    checkOutput("reset stable", 32'(btn_stable), 32'h0);
    checkOutput("reset pulses", 32'({press_pulse, release_pulse, long_pulse, repeat_pulse}), 32'h0);
    rst = 1'b0;
    k = 0;

    for (int v = 0; v < 17; v++) begin
      clearCounts();
      applyStimulus(vecs[v].pins);
      repeat (vecs[v].cycles) cycle();
      checkOutput($sformatf("vec%0d stable", v), 32'(btn_stable), 32'(vecs[v].expStable));
      checkOutput($sformatf("vec%0d press", v), 32'(packCounts(cntPress)), 32'(vecs[v].expPress));
      checkOutput($sformatf("vec%0d release", v), 32'(packCounts(cntRelease)), 32'(vecs[v].expRelease));
      checkOutput($sformatf("vec%0d long", v), 32'(packCounts(cntLong)), 32'(vecs[v].expLong));
      checkOutput($sformatf("vec%0d repeat", v), 32'(packCounts(cntRepeat)), 32'(vecs[v].expRepeat));
    end

    // Channels 0 and 3 pressed together at k=860: ticks 870/880/890, press at 891.
    clearCounts();
    applyStimulus(4'b0110);
    runTo(889);
    checkOutput("dual stable before", 32'(btn_stable), 32'h0);
    runTo(890);
    checkOutput("dual stable rise", 32'(btn_stable), 32'h9);
    checkOutput("dual press early", 32'(press_pulse), 32'h0);
    runTo(891);
    checkOutput("dual press", 32'(press_pulse), 32'h9);
    checkOutput("dual others", 32'({release_pulse, long_pulse, repeat_pulse}), 32'h0);
    runTo(892);
    checkOutput("dual press one cycle", 32'(press_pulse), 32'h0);
    applyStimulus(4'hF);
    runTo(920);
    checkOutput("dual release early", 32'(packCounts(cntRelease)), 32'h0);
    runTo(921);
    checkOutput("dual release", 32'(release_pulse), 32'h9);
    runTo(940);

    // Channel 2 pressed at 940 (stable at 970); released so stable falls at 1170,
    // the same tick that would complete the long-press count.
    clearCounts();
    applyStimulus(4'hB);
    runTo(971);
    checkOutput("prio press", 32'(press_pulse), 32'h4);
    runTo(1145);
    applyStimulus(4'hF);
    runTo(1169);
    checkOutput("prio stable held", 32'(btn_stable), 32'h4);
    runTo(1170);
    checkOutput("prio stable fall", 32'(btn_stable), 32'h0);
    runTo(1171);
    checkOutput("prio release", 32'(release_pulse), 32'h4);
    checkOutput("prio long now", 32'(long_pulse), 32'h0);
    runTo(1180);
    checkOutput("prio long count", 32'(packCounts(cntLong)), 32'h0);

    // Channel 2 pressed at 1180: press 1211, long 1411, first repeat 1461.
    clearCounts();
    applyStimulus(4'hB);
    runTo(1211);
    checkOutput("long press", 32'(press_pulse), 32'h4);
    runTo(1410);
    checkOutput("long early count", 32'(packCounts(cntLong)), 32'h0);
    runTo(1411);
    checkOutput("long pulse", 32'(long_pulse), 32'h4);
    runTo(1460);
    checkOutput("repeat early count", 32'(packCounts(cntRepeat)), 32'h0);
    runTo(1461);
    checkOutput("repeat pulse", 32'(repeat_pulse), 32'h4);
    runTo(1470);

    // Reset while channel 2 is in LONG with the pin still held.
    clearCounts();
    rst = 1'b1;
    cycle();
    checkOutput("midreset stable", 32'(btn_stable), 32'h0);
    checkOutput("midreset pulses", 32'({press_pulse, release_pulse, long_pulse, repeat_pulse}), 32'h0);
    rst = 1'b0;
    k = 0;
    runTo(29);
    checkOutput("resume stable before", 32'(btn_stable), 32'h0);
    runTo(30);
    checkOutput("resume stable", 32'(btn_stable), 32'h4);
    runTo(31);
    checkOutput("resume press", 32'(press_pulse), 32'h4);
    checkOutput("resume no release", 32'(packCounts(cntRelease)), 32'h0);
    runTo(40);
    applyStimulus(4'hF);
    runTo(71);
    checkOutput("resume release", 32'(release_pulse), 32'h4);
    runTo(80);

    checkOutput("pulse exclusivity", 32'(overlaps), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btn_event_gen.md
BTN_EVENT_GEN -- requirements
Module: btn_event_gen

Interface
REQ-001 Parameter N_BTN, default 4, number of independent button channels (1..32).
REQ-002 Parameter CLK_FREQ_HZ, default 50_000_000, clk frequency; SHALL be a multiple of 1000 and at least 1000.
REQ-003 Parameter DEBOUNCE_MS, default 10, debounce time in ms (>=1).
REQ-004 Parameter LONG_MS, default 1000, hold time before long-press event in ms (>=1).
REQ-005 Parameter REPEAT_MS, default 200, auto-repeat period after long press in ms; 0 disables repeat.
REQ-006 Parameter ACTIVE_LOW, default 1, 1 = pressed reads 0, 0 = pressed reads 1.
REQ-007 clk  input  1  sole clock; one clock domain.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 button_in  input  N_BTN  raw asynchronous button pins.
REQ-010 btn_stable  output  N_BTN  debounced level, 1 = pressed.
REQ-011 press_pulse  output  N_BTN  1-cycle pulse per debounced press.
REQ-012 release_pulse  output  N_BTN  1-cycle pulse per debounced release.
REQ-013 long_pulse  output  N_BTN  1-cycle pulse when a press reaches LONG_MS.
REQ-014 repeat_pulse  output  N_BTN  1-cycle pulse every REPEAT_MS while long-held.

Function
REQ-015 Each channel SHALL pass button_in through a 2-flop synchroniser, then invert if ACTIVE_LOW=1, giving level raw[i].
REQ-016 One shared prescaler SHALL assert ms_tick for 1 cycle every CLK_FREQ_HZ/1000 cycles (first tick CLK_FREQ_HZ/1000 cycles after reset release).
REQ-017 Debounce: on ms_tick with raw[i]!=btn_stable[i], db_cnt[i] increments; at DEBOUNCE_MS-1, btn_stable[i]<=raw[i] and db_cnt[i]<=0 instead.
REQ-018 Any cycle with raw[i]==btn_stable[i] SHALL clear db_cnt[i]; glitches shorter than DEBOUNCE_MS ticks never change btn_stable.
REQ-019 Per-channel FSM states IDLE, HELD, LONG; transitions use btn_stable[i] and its 1-cycle delayed copy.
REQ-020 IDLE->HELD on btn_stable rise: press_pulse[i] high the cycle after btn_stable[i] rises; hold_cnt[i]<=0.
REQ-021 HELD: hold_cnt increments on ms_tick; on tick where hold_cnt==LONG_MS-1, long_pulse[i] next cycle, hold_cnt<=0, go LONG.
REQ-022 LONG with REPEAT_MS>0: hold_cnt increments on ms_tick; at REPEAT_MS-1, repeat_pulse[i] next cycle, hold_cnt<=0, stay LONG; REPEAT_MS=0 holds LONG silently.
REQ-023 HELD or LONG -> IDLE on btn_stable fall: release_pulse[i] the cycle after the fall; a fall has priority over a same-cycle long/repeat event, which SHALL be suppressed.
REQ-024 hold_cnt width SHALL be $clog2(max(LONG_MS,REPEAT_MS)+1); db_cnt width $clog2(DEBOUNCE_MS+1); counters never wrap.
REQ-025 Channels SHALL be fully independent; pulses on multiple channels in the same cycle are legal.
REQ-026 All pulse outputs SHALL be registered; at most one of press/long/repeat/release per channel per cycle.

Reset
REQ-027 rst high at a clk edge SHALL set: sync flops to inactive pin level (all 1 if ACTIVE_LOW=1), btn_stable=0, all pulses=0, FSMs=IDLE, db_cnt, hold_cnt, prescaler=0.
REQ-028 rst asserted mid-press SHALL produce no release_pulse; a button still held after rst deasserts yields press_pulse after debounce.

Verification (CLK_FREQ_HZ=10_000 -> tick every 10 clk, DEBOUNCE_MS=3, LONG_MS=20, REPEAT_MS=5, N_BTN=4, ACTIVE_LOW=1)
REQ-029 button_in[0] low held 100 clk -> btn_stable[0] rises within 30..40 clk + 2 sync; exactly one press_pulse[0] next cycle.
REQ-030 button_in[1] low 15 clk then high, repeated 5x -> btn_stable[1] stays 0, no pulses.
REQ-031 button_in[2] low 400 clk -> press, long_pulse at 20 ticks after press, repeat_pulse at +5 and +10 and +15 ticks, then release_pulse ~3 ticks after pin high.
REQ-032 button_in[0] and [3] pressed same cycle -> press_pulse[0] and [3] in same cycle; other channels idle.
REQ-033 Release timed so btn_stable falls on the long-threshold tick -> release_pulse only, no long_pulse.
REQ-034 rst pulse while channel 2 in LONG -> all outputs 0 next cycle, no release_pulse; press resumes after debounce.
